cpu_run_ctrl: RTL and testbench

- Synthesizable run-control and trace block that sits between the system clock/reset and the 16-bit CPU core.
- It replaces hand-toggled clock/reset stimulus with commanded operations:
  - CPU reset pulse
  - single step
  - run N cycles
  - free run
  - halt
  - instruction breakpoint
- It captures {inst, s2} of every executed cycle into a circular trace buffer for readout.
- Width, trace depth and reset length are parametrised for the next CPU generation.

---
 rtl/cpu_run_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run-control and trace block for the 16-bit CPU: commanded reset, step, run-N,
// free run, halt and instruction breakpoint, plus a circular {inst,s2} trace buffer.
module cpu_run_ctrl #(
  parameter int unsigned IW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned CW      = 16,
  parameter int unsigned RST_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [CW-1:0]      cmd_count,
  input  logic               bp_en,
  input  logic [IW-1:0]      bp_inst,
  input  logic [IW-1:0]      inst,
  input  logic [DW-1:0]      s2,
  output logic               cpu_en,
  output logic               cpu_rst,
  output logic               busy,
  output logic               halted_bp,
  output logic [CW-1:0]      cyc_cnt,
  input  logic [AW-1:0]      tr_addr,
  output logic [IW+DW-1:0]   tr_data,
  output logic [AW:0]        tr_count,
  output logic               tr_wrap
);

  localparam int unsigned TW  = IW + DW;
  localparam int unsigned RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [AW:0] TR_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_STEP  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CRST = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           r_state;
  logic [RCW-1:0]   r_rst_cnt;
  logic [CW-1:0]    r_remain;
  logic             r_cpu_rst;
  logic             r_busy;
  logic             r_cmd_ready;
  logic             r_halted_bp;
  logic [CW-1:0]    r_cyc_cnt;
  logic [AW-1:0]    r_wptr;
  logic [AW:0]      r_tr_count;
  logic             r_tr_wrap;
  logic [TW-1:0]    r_buf [DEPTH];

  state_t           w_state_nxt;
  logic [RCW-1:0]   w_rst_cnt_nxt;
  logic [CW-1:0]    w_remain_nxt;
  logic             w_cpu_rst_nxt;
  logic             w_hbp_nxt;
  logic             w_clear;
  logic             w_cpu_en;
  logic             w_fire;
  logic             w_bp_hit;
  logic [AW-1:0]    w_rd_idx;

  assign w_fire   = cmd_valid && r_cmd_ready;
  assign w_bp_hit = bp_en && (inst == bp_inst);

  // Next-state and per-cycle control decode
  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    w_remain_nxt  = r_remain;
    w_cpu_rst_nxt = r_cpu_rst;
    w_hbp_nxt     = r_halted_bp;
    w_clear       = 1'b0;
    w_cpu_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fire) begin
          case (cmd_op)
            OP_RESET: begin
              w_state_nxt   = ST_CRST;
              w_rst_cnt_nxt = RCW'(RST_CYC - 1);
              w_cpu_rst_nxt = 1'b0;
              w_hbp_nxt     = 1'b0;
              w_clear       = 1'b1;
            end
            OP_STEP, OP_RUN: begin
              w_hbp_nxt = 1'b0;
              // A CPU never released from reset cannot be stepped
              if (r_cpu_rst) begin
                w_state_nxt  = ST_RUN;
                w_remain_nxt = (cmd_op == OP_STEP) ? CW'(1) : cmd_count;
              end
            end
            default: ;
          endcase
        end
      end
      ST_CRST: begin
        if (r_rst_cnt == '0) begin
          w_state_nxt   = ST_IDLE;
          w_cpu_rst_nxt = 1'b1;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt - RCW'(1);
        end
      end
      ST_RUN: begin
        w_cpu_en = !w_bp_hit;
        if (w_fire && (cmd_op == OP_HALT)) begin
          w_state_nxt = ST_IDLE;
        end else if (w_bp_hit) begin
          w_hbp_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_remain == CW'(1)) begin
          w_state_nxt = ST_IDLE;
        end else if (r_remain != '0) begin
          w_remain_nxt = r_remain - CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, control and trace bookkeeping registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_rst_cnt   <= '0;
      r_remain    <= '0;
      r_cpu_rst   <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_halted_bp <= 1'b0;
      r_cyc_cnt   <= '0;
      r_wptr      <= '0;
      r_tr_count  <= '0;
      r_tr_wrap   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rst_cnt   <= w_rst_cnt_nxt;
      r_remain    <= w_remain_nxt;
      r_cpu_rst   <= w_cpu_rst_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_cmd_ready <= (w_state_nxt != ST_CRST);
      r_halted_bp <= w_hbp_nxt;
      if (w_clear) begin
        r_cyc_cnt  <= '0;
        r_wptr     <= '0;
        r_tr_count <= '0;
        r_tr_wrap  <= 1'b0;
      end else if (w_cpu_en) begin
        if (r_cyc_cnt != '1) r_cyc_cnt <= r_cyc_cnt + CW'(1);
        r_wptr <= r_wptr + AW'(1);
        if (r_tr_count != TR_FULL) r_tr_count <= r_tr_count + (AW+1)'(1);
        else                       r_tr_wrap  <= 1'b1;
      end
    end
  end

  // Trace RAM: no reset, contents only meaningful below tr_count
  always_ff @(posedge clk) begin
    if (w_cpu_en) r_buf[r_wptr] <= {inst, s2};
  end

  // Once wrapped, the write pointer marks the oldest entry
  assign w_rd_idx = (r_tr_wrap ? r_wptr : AW'(0)) + tr_addr;

  assign cmd_ready = r_cmd_ready;
  assign cpu_en    = w_cpu_en;
  assign cpu_rst   = r_cpu_rst;
  assign busy      = r_busy;
  assign halted_bp = r_halted_bp;
  assign cyc_cnt   = r_cyc_cnt;
  assign tr_data   = r_buf[w_rd_idx];
  assign tr_count  = r_tr_count;
  assign tr_wrap   = r_tr_wrap;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: hand-derived command vectors, corner sequences and a
// randomized phase, all checked cycle by cycle against a queue-based trace model.
module tb_cpu_run_ctrl;

  localparam int unsigned IW = 16, DW = 16, DEPTH = 16, AW = 4, CW = 16, RST_CYC = 2;

  logic              clk, rst;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [CW-1:0]     cmd_count;
  logic              bp_en;
  logic [IW-1:0]     bp_inst, inst;
  logic [DW-1:0]     s2;
  logic              cpu_en, cpu_rst, busy, halted_bp, tr_wrap;
  logic [CW-1:0]     cyc_cnt;
  logic [AW-1:0]     tr_addr;
  logic [IW+DW-1:0]  tr_data;
  logic [AW:0]       tr_count;

  cpu_run_ctrl #(.IW(IW), .DW(DW), .DEPTH(DEPTH), .AW(AW), .CW(CW), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_count(cmd_count), .bp_en(bp_en), .bp_inst(bp_inst), .inst(inst), .s2(s2),
    .cpu_en(cpu_en), .cpu_rst(cpu_rst), .busy(busy), .halted_bp(halted_bp),
    .cyc_cnt(cyc_cnt), .tr_addr(tr_addr), .tr_data(tr_data), .tr_count(tr_count),
    .tr_wrap(tr_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: mode 0 idle, 1 cpu reset, 2 running
  int           m_mode, m_rleft, m_remain, m_cyc, m_total;
  bit           m_cpu_rst, m_hbp;
  logic [31:0]  hist[$];

  typedef struct {
    logic [1:0]  op;
    logic [15:0] count;
    bit          bpe;
    int          bp_tick;
    int          ticks;
    int          e_en;
    int          e_rstlow;
    int          e_cyc;
    int          e_trc;
    bit          e_wrap;
    bit          e_hbp;
    logic [15:0] e_rd_first;
    logic [15:0] e_rd_last;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_rleft = 0; m_remain = 0; m_cyc = 0; m_total = 0;
    m_cpu_rst = 1'b0; m_hbp = 1'b0;
    hist.delete();
  endfunction

  task automatic check_now();
    bit bp;
    int cnt;
    bp  = bp_en && (inst == bp_inst);
    cnt = (m_total > int'(DEPTH)) ? int'(DEPTH) : m_total;
    chk("cpu_en", cpu_en, (m_mode == 2) && !bp);
    chk("cmd_ready", cmd_ready, m_mode != 1);
    chk("cpu_rst", cpu_rst, m_cpu_rst);
    chk("busy", busy, m_mode != 0);
    chk("halted_bp", halted_bp, m_hbp);
    chk("cyc_cnt", cyc_cnt, m_cyc);
    chk("tr_count", tr_count, cnt);
    chk("tr_wrap", tr_wrap, m_total > int'(DEPTH));
    if (int'(tr_addr) < cnt) chk("tr_data", tr_data, hist[tr_addr]);
  endtask

  function automatic void model_edge();
    bit bp, fire;
    bp   = bp_en && (inst == bp_inst);
    fire = cmd_valid && (m_mode != 1);
    if (m_mode == 2 && !bp) begin
      hist.push_back({inst, s2});
      if (hist.size() > DEPTH) void'(hist.pop_front());
      m_total++;
      if (m_cyc < 65535) m_cyc++;
    end
    case (m_mode)
      0: if (fire) begin
        if (cmd_op == 2'd0) begin
          m_mode = 1; m_rleft = RST_CYC; m_cpu_rst = 1'b0; m_hbp = 1'b0;
          m_cyc = 0; m_total = 0; hist.delete();
        end else if (cmd_op != 2'd3) begin
          m_hbp = 1'b0;
          if (m_cpu_rst) begin
            m_mode   = 2;
            m_remain = (cmd_op == 2'd1) ? 1 : int'(cmd_count);
          end
        end
      end
      1: begin
        m_rleft--;
        if (m_rleft == 0) begin m_mode = 0; m_cpu_rst = 1'b1; end
      end
      default: begin
        if (fire && cmd_op == 2'd3) m_mode = 0;
        else if (bp) begin m_hbp = 1'b1; m_mode = 0; end
        else if (m_remain == 1) m_mode = 0;
        else if (m_remain > 1) m_remain--;
      end
    endcase
  endfunction

  // Called just after a falling edge with inputs already driven
  task automatic tick();
    #1;
    check_now();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input logic [15:0] cnt,
                       input bit bpe, input logic [15:0] in);
    cmd_valid = v; cmd_op = op; cmd_count = cnt;
    bp_en = bpe; bp_inst = 16'h8000; inst = in; s2 = 16'($urandom);
  endtask

  task automatic issue(input logic [1:0] op, input int idle_ticks);
    drive(1'b1, op, 16'd0, 1'b0, 16'h0100);
    tick();
    for (int k = 0; k < idle_ticks; k++) begin
      drive(1'b0, 2'd0, 16'd0, 1'b0, 16'h0100);
      tick();
    end
  endtask

  task automatic async_rst();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_cpu_rst", cpu_rst, 1'b0);
    chk("arst_cpu_en", cpu_en, 1'b0);
    chk("arst_tr_count", tr_count, 0);
    chk("arst_busy", busy, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int en_cnt, rl_cnt;
    // {op, count, bp_en, bp_tick, ticks, en, rst_low, cyc, trc, wrap, hbp, rd_first, rd_last}
    vecs[0] = '{2'd0, 16'd0,  1'b0, -1, 4,  0,  2, 0,  0,  1'b0, 1'b0, 16'h0,    16'h0};
    vecs[1] = '{2'd1, 16'd0,  1'b0, -1, 2,  1,  0, 1,  1,  1'b0, 1'b0, 16'h1011, 16'h1011};
    vecs[2] = '{2'd1, 16'd0,  1'b0, -1, 2,  1,  0, 2,  2,  1'b0, 1'b0, 16'h1011, 16'h1021};
    vecs[3] = '{2'd1, 16'd0,  1'b0, -1, 2,  1,  0, 3,  3,  1'b0, 1'b0, 16'h1011, 16'h1031};
    vecs[4] = '{2'd0, 16'd0,  1'b0, -1, 4,  0,  2, 0,  0,  1'b0, 1'b0, 16'h0,    16'h0};
    vecs[5] = '{2'd2, 16'd20, 1'b0, -1, 24, 20, 0, 20, 16, 1'b1, 1'b0, 16'h1055, 16'h1064};
    vecs[6] = '{2'd0, 16'd0,  1'b0, -1, 4,  0,  2, 0,  0,  1'b0, 1'b0, 16'h0,    16'h0};
    vecs[7] = '{2'd2, 16'd0,  1'b1, 7,  10, 6,  0, 6,  6,  1'b0, 1'b1, 16'h1071, 16'h1076};
    vecs[8] = '{2'd1, 16'd0,  1'b1, 1,  3,  0,  0, 6,  6,  1'b0, 1'b1, 16'h1071, 16'h1076};
    vecs[9] = '{2'd1, 16'd0,  1'b0, -1, 2,  1,  0, 7,  7,  1'b0, 1'b0, 16'h1071, 16'h1091};

    rst = 1'b0; tr_addr = '0;
    drive(1'b0, 2'd0, 16'd0, 1'b0, 16'h0);
    model_reset();
    @(negedge clk);
    tick();
    tick();
    rst = 1'b1;

    // Command vectors with hand-derived outcomes
    for (int i = 0; i < 10; i++) begin
      en_cnt = 0; rl_cnt = 0;
      for (int t = 0; t < vecs[i].ticks; t++) begin
        drive(t == 0, vecs[i].op, vecs[i].count, vecs[i].bpe,
              (t == vecs[i].bp_tick) ? 16'h8000 : 16'(4096 + 16 * i + t));
        tr_addr = AW'($urandom);
        #1;
        if (cpu_en) en_cnt++;
        tick();
        if (!cpu_rst) rl_cnt++;
      end
      drive(1'b0, 2'd0, 16'd0, 1'b0, 16'h0200);
      tr_addr = '0;
      #1;
      chk($sformatf("v%0d_en_cycles", i), en_cnt, vecs[i].e_en);
      chk($sformatf("v%0d_rst_low", i), rl_cnt, vecs[i].e_rstlow);
      chk($sformatf("v%0d_cyc_cnt", i), cyc_cnt, vecs[i].e_cyc);
      chk($sformatf("v%0d_tr_count", i), tr_count, vecs[i].e_trc);
      chk($sformatf("v%0d_tr_wrap", i), tr_wrap, vecs[i].e_wrap);
      chk($sformatf("v%0d_halted_bp", i), halted_bp, vecs[i].e_hbp);
      chk($sformatf("v%0d_busy", i), busy, 1'b0);
      if (vecs[i].e_trc > 0) begin
        chk($sformatf("v%0d_rd_first", i), tr_data[31:16], vecs[i].e_rd_first);
        tr_addr = AW'(vecs[i].e_trc - 1);
        #1;
        chk($sformatf("v%0d_rd_last", i), tr_data[31:16], vecs[i].e_rd_last);
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end

    // Free run; RESET mid-run is dropped, HALT cycle still executes
    issue(2'd0, 3);
    en_cnt = 0;
    for (int t = 0; t < 14; t++) begin
      drive(t == 0 || t == 5 || t == 10, (t == 0) ? 2'd2 : (t == 5) ? 2'd0 : 2'd3,
            16'd0, 1'b0, 16'(16'h2000 + t));
      #1;
      if (cpu_en) en_cnt++;
      tick();
    end
    chk("halt_en_cycles", en_cnt, 10);
    chk("halt_cyc_cnt", cyc_cnt, 10);
    chk("halt_cpu_rst", cpu_rst, 1'b1);
    chk("halt_busy", busy, 1'b0);

    // Async reset mid-run, then STEP ignored until a RESET completes
    for (int t = 0; t < 4; t++) begin
      drive(t == 0, 2'd2, 16'd0, 1'b0, 16'(16'h3000 + t));
      tick();
    end
    drive(1'b0, 2'd0, 16'd0, 1'b0, 16'h3004);
    async_rst();
    en_cnt = 0;
    drive(1'b1, 2'd1, 16'd0, 1'b0, 16'h3005);
    tick();
    for (int t = 0; t < 3; t++) begin
      drive(1'b0, 2'd0, 16'd0, 1'b0, 16'h3006);
      #1;
      if (cpu_en) en_cnt++;
      tick();
    end
    chk("arst_step_ignored", en_cnt, 0);
    chk("arst_step_cyc", cyc_cnt, 0);
    issue(2'd0, 3);
    issue(2'd1, 2);
    chk("arst_step_after_reset", cyc_cnt, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) async_rst();
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom);
      cmd_count = 16'($urandom_range(0, 30));
      bp_en     = ($urandom_range(0, 3) == 0);
      bp_inst   = 16'($urandom_range(0, 7));
      inst      = 16'($urandom_range(0, 15));
      s2        = 16'($urandom);
      tr_addr   = AW'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
